// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and one-hot/binary helpers for the decoder_2x4 / encoder family
package enc_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = $clog2(N_DEF);
  function automatic logic [W_DEF-1:0] onehot2bin(input logic [N_DEF-1:0] oh);
    onehot2bin = '0;
    for (int i = 0; i < N_DEF; i++) if (oh[i]) onehot2bin = W_DEF'(i);
  endfunction
  function automatic logic [N_DEF-1:0] bin2onehot(input logic [W_DEF-1:0] b);
    return N_DEF'(1) << b;
  endfunction
endpackage

// File: rtl/enc_prio_sel.sv
// enc_prio_sel: picks the first set candidate walking from i_start (ascending or descending, wrapping)
module enc_prio_sel
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N),
  parameter bit ASC = 1'b0
) (
  input  logic [N-1:0] i_cand,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_sel,
  output logic         o_any
);
  logic [W-1:0] w_idx [N];
  for (genvar g = 0; g < N; g++) begin : g_idx
    assign w_idx[g] = ASC ? i_start + W'(g) : i_start - W'(g);
  end
  // walk farthest-first so the closest hit to i_start overrides
  always_comb begin
    o_sel = i_start;
    for (int i = N - 1; i >= 0; i--) if (i_cand[w_idx[i]]) o_sel = w_idx[i];
  end
  assign o_any = |i_cand;
endmodule

// File: rtl/encoder_4x2_arb.sv
// encoder_4x2_arb: pending-flag request encoder issuing binary codes on valid/ready; ROUND_ROBIN_EN selects rotating priority
module encoder_4x2_arb
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [N-1:0] pending,
  output logic         coalesce,
  input  logic         clr_err
);
  logic [N-1:0] r_pending;
  logic [W-1:0] r_dout;
  logic         r_valid;
  logic         r_coal;
  logic [N-1:0] w_req;
  logic [N-1:0] w_cand;
  logic [W-1:0] w_sel;
  logic [W-1:0] w_start;
  logic         w_any;
  logic         w_load;
  logic         w_dup;
  assign w_req  = en ? din : '0;
  assign w_cand = r_pending | w_req;
  assign w_load = !r_valid || dout_ready;
  assign w_dup  = |(w_req & r_pending) || (r_valid && !dout_ready && w_req[r_dout]);
`ifdef ROUND_ROBIN_EN
  logic [W-1:0] r_rr_ptr;
  assign w_start = r_rr_ptr + 1'b1;
  // pointer remembers the last code loaded so the next search starts past it
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rr_ptr <= W'(N - 1);
    else if (w_load && w_any) r_rr_ptr <= w_sel;
  enc_prio_sel #(.N(N), .W(W), .ASC(1'b1)) u_sel (
    .i_cand(w_cand), .i_start(w_start), .o_sel(w_sel), .o_any(w_any)
  );
`else
  assign w_start = W'(N - 1);
  enc_prio_sel #(.N(N), .W(W), .ASC(1'b0)) u_sel (
    .i_cand(w_cand), .i_start(w_start), .o_sel(w_sel), .o_any(w_any)
  );
`endif
  // output slot reloads whenever it is empty or being consumed; otherwise requests accumulate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_coal    <= 1'b0;
    end else begin
      if (w_load && w_any) begin
        r_dout    <= w_sel;
        r_valid   <= 1'b1;
        r_pending <= w_cand & ~(N'(1) << w_sel);
      end else if (w_load) begin
        r_valid   <= 1'b0;
        r_pending <= '0;
      end else r_pending <= w_cand;
      r_coal <= w_dup ? 1'b1 : clr_err ? 1'b0 : r_coal;
    end
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign pending    = r_pending;
  assign coalesce   = r_coal;
endmodule

// File: tb/tb_encoder_4x2_arb.sv
// tb_encoder_4x2_arb: directed scenarios plus random traffic checked against a set-of-pending-codes model
module tb_encoder_4x2_arb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] din = 4'b0;
  logic [1:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [3:0] pending;
  logic       coalesce;
  logic       clr_err = 1'b0;
  int tests = 0;
  int fails = 0;
  int         m_dout = 0;
  bit         m_valid = 0;
  logic [3:0] m_pend = 4'b0;
  bit         m_coal = 0;
  int         m_rr = 3;

  encoder_4x2_arb dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .pending(pending), .coalesce(coalesce), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input int rr);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (c[(rr + k) % 4]) return (rr + k) % 4;
`else
    for (int i = 3; i >= 0; i--) if (c[i]) return i;
`endif
    return -1;
  endfunction

  task automatic cyc(input bit e, input logic [3:0] d, input bit r, input bit c);
    logic [3:0] req;
    logic [3:0] cand;
    bit dup;
    int p;
    en = e; din = d; dout_ready = r; clr_err = c;
    req  = e ? d : 4'b0;
    cand = m_pend | req;
    dup  = ((req & m_pend) != 4'b0) || (m_valid && !r && req[m_dout]);
    @(posedge clk);
    if (!m_valid || r) begin
      p = pick(cand, m_rr);
      if (p >= 0) begin
        m_dout = p; m_valid = 1; cand[p] = 1'b0; m_pend = cand; m_rr = p;
      end else begin
        m_valid = 0; m_pend = 4'b0;
      end
    end else m_pend = cand;
    m_coal = dup ? 1'b1 : (c ? 1'b0 : m_coal);
    #1;
  endtask

  task automatic exp_st(input string nm, input int d, input int v, input int p, input int co);
    chk({nm, ".dout"}, dout, d);
    chk({nm, ".valid"}, dout_valid, v);
    chk({nm, ".pending"}, pending, p);
    chk({nm, ".coalesce"}, coalesce, co);
    chk({nm, ".model"}, (m_dout << 6) | (int'(m_valid) << 5) | (int'(m_pend) << 1) | int'(m_coal),
        (d << 6) | (v << 5) | (p << 1) | co);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_dout = 0; m_valid = 0; m_pend = 4'b0; m_coal = 0; m_rr = 3;
    #2;
    exp_st("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("cmp.dout", dout, m_dout);
    chk("cmp.valid", dout_valid, m_valid);
    chk("cmp.pending", pending, m_pend);
    chk("cmp.coalesce", coalesce, m_coal);
  end

  initial begin
    do_reset();
    cyc(1, 4'b0100, 1, 0); exp_st("s1.load", 2, 1, 0, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s1.drain", 2, 0, 0, 0);

    do_reset();
`ifdef ROUND_ROBIN_EN
    cyc(1, 4'b1011, 1, 0); exp_st("s2.a", 0, 1, 4'b1010, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.b", 1, 1, 4'b1000, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.c", 3, 1, 0, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.d", 3, 0, 0, 0);
`else
    cyc(1, 4'b1011, 1, 0); exp_st("s2.a", 3, 1, 4'b0011, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.b", 1, 1, 4'b0001, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.c", 0, 1, 0, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s2.d", 0, 0, 0, 0);
`endif

    do_reset();
    cyc(1, 4'b0010, 0, 0); exp_st("s3.load", 1, 1, 0, 0);
    cyc(1, 4'b0010, 0, 0); exp_st("s3.coal", 1, 1, 4'b0010, 1);
    cyc(0, 4'b0000, 0, 1); exp_st("s3.clr", 1, 1, 4'b0010, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s3.rel", 1, 1, 0, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s3.idle", 1, 0, 0, 0);

    do_reset();
    cyc(1, 4'b1000, 0, 0); exp_st("s4.load", 3, 1, 0, 0);
    cyc(1, 4'b0001, 0, 0); exp_st("s4.queue", 3, 1, 4'b0001, 0);
    cyc(0, 4'b1111, 0, 0); exp_st("s4.en0", 3, 1, 4'b0001, 0);
    cyc(0, 4'b1111, 1, 0); exp_st("s4.issue", 0, 1, 0, 0);
    cyc(0, 4'b1111, 1, 0); exp_st("s4.idle", 0, 0, 0, 0);

    do_reset();
    cyc(1, 4'b0001, 0, 0);
    cyc(1, 4'b0100, 0, 0);
    cyc(1, 4'b1000, 0, 0);
    repeat (3) cyc(0, 4'b0000, 0, 0);
    exp_st("s5.hold", 0, 1, 4'b1100, 0);
`ifdef ROUND_ROBIN_EN
    cyc(0, 4'b0000, 1, 0); exp_st("s5.a", 2, 1, 4'b1000, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s5.b", 3, 1, 0, 0);
`else
    cyc(0, 4'b0000, 1, 0); exp_st("s5.a", 3, 1, 4'b0100, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s5.b", 2, 1, 0, 0);
`endif

    do_reset();
    cyc(1, 4'b0001, 0, 0);
    cyc(1, 4'b0110, 0, 0); exp_st("s6.pre", 0, 1, 4'b0110, 0);
    do_reset();
    cyc(0, 4'b0000, 1, 0); exp_st("s6.post1", 0, 0, 0, 0);
    cyc(0, 4'b0000, 1, 0); exp_st("s6.post2", 0, 0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(63) == 0) do_reset();
      else cyc($urandom_range(3) != 0, 4'($urandom & $urandom), $urandom_range(2) != 0,
               $urandom_range(7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
